// File: rtl/mul_div_ctrl.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock over a 64-bit accumulator,
// with optional single-cycle early-out for divide-by-zero and signed overflow.
module mul_div_ctrl #(
  parameter int EARLY_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [63:0] acc;
  logic [31:0] opd_b;
  logic        neg_q;
  logic [31:0] resp_data_q;

  logic        a_signed, b_signed, sa, sb, neg_entry;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, early;
  logic [31:0] early_data;

  // Operand conditioning at accept time: magnitudes, result sign, early-out detection
  always_comb begin
    a_signed = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010) ||
               (req_op == 3'b100) || (req_op == 3'b110);
    b_signed = (req_op == 3'b000) || (req_op == 3'b001) ||
               (req_op == 3'b100) || (req_op == 3'b110);
    sa = a_signed && req_a[31];
    sb = b_signed && req_b[31];
    a_mag = sa ? ((~req_a) + 32'd1) : req_a;
    b_mag = sb ? ((~req_b) + 32'd1) : req_b;
    // A zero divisor must leave the all-ones quotient un-negated
    case (req_op)
      3'b000, 3'b001, 3'b010: neg_entry = sa ^ sb;
      3'b100:                 neg_entry = (sa ^ sb) && (req_b != 32'd0);
      3'b110:                 neg_entry = sa;
      default:                neg_entry = 1'b0;
    endcase
    div_zero = req_op[2] && (req_b == 32'd0);
    div_ovf  = req_op[2] && !req_op[0] &&
               (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
    early    = (EARLY_OUT != 0) && (div_zero || div_ovf);
    if (div_zero)
      early_data = req_op[1] ? req_a : 32'hFFFF_FFFF;
    else
      early_data = req_op[1] ? 32'd0 : 32'h8000_0000;
  end

  logic [32:0] mul_sum, div_rem, div_diff;
  logic [63:0] mul_next, div_next, acc_next, mul_res;
  logic [31:0] div_sel, div_res, calc_data;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd_b} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    div_rem  = acc[63:31];
    div_diff = div_rem - {1'b0, opd_b};
    div_next = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
    acc_next = op_q[2] ? div_next : mul_next;
    mul_res  = neg_q ? (64'd0 - acc_next) : acc_next;
    div_sel  = op_q[1] ? acc_next[63:32] : acc_next[31:0];
    div_res  = neg_q ? (32'd0 - div_sel) : div_sel;
    if (op_q[2])
      calc_data = div_res;
    else if (op_q == 3'b000)
      calc_data = mul_res[31:0];
    else
      calc_data = mul_res[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      op_q        <= 3'd0;
      acc         <= 64'd0;
      opd_b       <= 32'd0;
      neg_q       <= 1'b0;
      resp_data_q <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            cnt  <= 5'd0;
            if (early) begin
              state       <= DONE;
              resp_data_q <= early_data;
            end else begin
              state <= CALC;
              acc   <= {32'd0, a_mag};
              opd_b <= b_mag;
              neg_q <= neg_entry;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state       <= DONE;
            resp_data_q <= calc_data;
          end
        end
        DONE: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = rst_n && (state == IDLE) && !flush;
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl: an EARLY_OUT=1 and an EARLY_OUT=0 instance share
// the same stimulus so both timing variants are checked side by side.
module tb_mul_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b1;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;

  logic        req_ready_e, resp_valid_e, busy_e;
  logic [31:0] resp_data_e;
  logic        req_ready_n, resp_valid_n, busy_n;
  logic [31:0] resp_data_n;

  int checks = 0;
  int errors = 0;

  int          lat_e, lat_n, busy_cnt_e, busy_low_e;
  logic [31:0] data_e, data_n;

  mul_div_ctrl #(.EARLY_OUT(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_e),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid_e), .resp_ready(resp_ready), .resp_data(resp_data_e),
    .busy(busy_e)
  );

  mul_div_ctrl #(.EARLY_OUT(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_n),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid_n), .resp_ready(resp_ready), .resp_data(resp_data_n),
    .busy(busy_n)
  );

  always #5 clk = ~clk;

  // Present one request for a single accept edge, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'b000; req_a = 32'h1234_5678; req_b = 32'h0000_0003;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    lat_e = 0; lat_n = 0; busy_cnt_e = 0; busy_low_e = 0;
    data_e = 32'd0; data_n = 32'd0;
    issue(op, a, b);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (resp_valid_e && lat_e == 0) begin lat_e = c; data_e = resp_data_e; end
      if (resp_valid_n && lat_n == 0) begin lat_n = c; data_n = resp_data_n; end
      if (busy_e) busy_cnt_e++;
      else if (busy_low_e == 0) busy_low_e = c;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({req_ready_e, resp_valid_e, busy_e, resp_data_e} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_state_e got %b_%b_%b_%h expected 0_0_0_00000000",
               req_ready_e, resp_valid_e, busy_e, resp_data_e);
    end
    checks++;
    if ({req_ready_n, resp_valid_n, busy_n, resp_data_n} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_state_n got %b_%b_%b_%h expected 0_0_0_00000000",
               req_ready_n, resp_valid_n, busy_n, resp_data_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready_e, req_ready_n} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got %b expected 11", {req_ready_e, req_ready_n});
    end
  endtask

  task automatic test_mul_basic;
    run_op(3'b000, 32'd7, 32'd6);
    checks++;
    if (lat_e !== 33 || lat_n !== 33) begin
      errors++;
      $display("[TB] FAIL mul_latency got %0d/%0d expected 33/33", lat_e, lat_n);
    end
    checks++;
    if (data_e !== 32'h2A || data_n !== 32'h2A) begin
      errors++;
      $display("[TB] FAIL mul_7x6 got %h/%h expected 0000002a", data_e, data_n);
    end
    checks++;
    if (busy_cnt_e !== 33 || busy_low_e !== 34) begin
      errors++;
      $display("[TB] FAIL mul_busy got %0d cycles low_at %0d expected 33 low_at 34",
               busy_cnt_e, busy_low_e);
    end
  endtask

  task automatic test_mul_corners;
    logic [2:0]  ops [4] = '{3'b001, 3'b011, 3'b010, 3'b000};
    logic [31:0] exps[4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if (data_e !== exps[i] || data_n !== exps[i] || lat_e !== 33) begin
        errors++;
        $display("[TB] FAIL mul_ones op%0d got %h/%h lat %0d expected %h lat 33",
                 ops[i], data_e, data_n, lat_e, exps[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFF_FFF9, 32'd2);
      checks++;
      if (data_e !== exps[i] || data_n !== exps[i] || lat_e !== 33) begin
        errors++;
        $display("[TB] FAIL div_m7_2 op%0d got %h/%h lat %0d expected %h lat 33",
                 ops[i], data_e, data_n, lat_e, exps[i]);
      end
    end
  endtask

  task automatic test_early_out;
    logic [2:0]  ops [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFF9};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i]);
      checks++;
      if (lat_e !== 1 || data_e !== exps[i]) begin
        errors++;
        $display("[TB] FAIL early_out case%0d got %h lat %0d expected %h lat 1",
                 i, data_e, lat_e, exps[i]);
      end
      checks++;
      if (lat_n !== 33 || data_n !== exps[i]) begin
        errors++;
        $display("[TB] FAIL iterated case%0d got %h lat %0d expected %h lat 33",
                 i, data_n, lat_n, exps[i]);
      end
    end
  endtask

  task automatic test_flush;
    logic seen;
    issue(3'b100, 32'd100, 32'd7);
    for (int c = 1; c <= 9; c++) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready_e, req_ready_n, resp_valid_e, resp_valid_n, busy_e, busy_n} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL flush_idle got %b expected 110000",
               {req_ready_e, req_ready_n, resp_valid_e, resp_valid_n, busy_e, busy_n});
    end
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (resp_valid_e || resp_valid_n) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_no_resp got %b expected 0", seen);
    end
    // A request offered alongside flush must be dropped
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 3'b000; req_a = 32'd2; req_b = 32'd2;
    #1;
    checks++;
    if ({req_ready_e, req_ready_n} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ready_during_flush got %b expected 00", {req_ready_e, req_ready_n});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_e, busy_n} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL flush_blocks_accept got %b expected 00", {busy_e, busy_n});
    end
    run_op(3'b000, 32'd3, 32'd5);
    checks++;
    if (data_e !== 32'hF || data_n !== 32'hF || lat_e !== 33) begin
      errors++;
      $display("[TB] FAIL mul_after_flush got %h/%h lat %0d expected 0000000f lat 33",
               data_e, data_n, lat_e);
    end
  endtask

  task automatic test_backpressure;
    resp_ready = 1'b0;
    issue(3'b000, 32'd9, 32'd9);
    for (int c = 1; c <= 32; c++) @(negedge clk);
    for (int c = 33; c <= 37; c++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid_e, req_ready_e, resp_data_e, resp_valid_n, req_ready_n, resp_data_n}
          !== {1'b1, 1'b0, 32'h51, 1'b1, 1'b0, 32'h51}) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d got %b%b_%h/%b%b_%h expected 10_00000051", c,
                 resp_valid_e, req_ready_e, resp_data_e, resp_valid_n, req_ready_n, resp_data_n);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'd1; req_b = 32'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_e, resp_valid_e, req_ready_e, busy_n, resp_valid_n, req_ready_n} !== 6'b001001) begin
      errors++;
      $display("[TB] FAIL release_to_idle got %b expected 001001",
               {busy_e, resp_valid_e, req_ready_e, busy_n, resp_valid_n, req_ready_n});
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    issue(3'b100, 32'd1000, 32'd3);
    for (int c = 1; c <= 19; c++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_e, resp_valid_e, busy_e, resp_data_e,
         req_ready_n, resp_valid_n, busy_n, resp_data_n} !== 70'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_calc got %b%b%b_%h/%b%b%b_%h expected zeros",
               req_ready_e, resp_valid_e, busy_e, resp_data_e,
               req_ready_n, resp_valid_n, busy_n, resp_data_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid_e || resp_valid_n || busy_e || busy_n) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_resp got %b expected 0", seen);
    end
    // Reset while a result is waiting in DONE
    resp_ready = 1'b0;
    issue(3'b000, 32'd2, 32'd3);
    for (int c = 1; c <= 33; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid_e, busy_e, resp_data_e, resp_valid_n, busy_n, resp_data_n} !== 68'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_done got %b%b_%h/%b%b_%h expected zeros",
               resp_valid_e, busy_e, resp_data_e, resp_valid_n, busy_n, resp_data_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid_e || resp_valid_n) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done_no_resp got %b expected 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_mul_basic;
    test_mul_corners;
    test_div;
    test_early_out;
    test_flush;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 The block SHALL have parameter EARLY_OUT, default 1, meaning 1 = divide-by-zero and signed-overflow cases bypass iteration.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: an operation is offered.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have port req_op, input, 3 bits: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have port req_a, input, 32 bits: rs1 (multiplicand or dividend).
REQ-008 The block SHALL have port req_b, input, 32 bits: rs2 (multiplier or divisor).
REQ-009 The block SHALL have port flush, input, 1 bit: pipeline kill.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a result is available.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port resp_data, output, 32 bits: the result.
REQ-013 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE; used as the pipeline stall.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 req_ready SHALL equal (state==IDLE) && !flush.
- Accept occurs on a clock edge where req_valid && req_ready.
- On accept, req_op, req_a and req_b SHALL be latched; later input changes have no effect.
REQ-016 On accept, if EARLY_OUT=1 and the operation is a divide/remainder with req_b==0, the FSM SHALL go IDLE->DONE.
- DIV/DIVU result: 0xFFFFFFFF.
- REM/REMU result: req_a.
REQ-017 On accept, if EARLY_OUT=1 and op is DIV or REM with req_a==0x80000000 and req_b==0xFFFFFFFF, the FSM SHALL go IDLE->DONE.
- DIV result: 0x80000000.
- REM result: 0x00000000.
REQ-018 For every other accept, the FSM SHALL go IDLE->CALC with the 5-bit iteration counter at 0.
REQ-019 Sign handling on entry to CALC:
- Signed operands (MUL/MULH: a,b; MULHSU: a only; DIV/REM: a,b) SHALL be converted to magnitudes.
- A result-negate flag SHALL be recorded: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
REQ-020 In CALC, each edge SHALL perform exactly one radix-2 step.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract over a 64-bit remainder:quotient register.
- The counter increments each step; the edge with counter==31 SHALL move CALC->DONE.
REQ-021 Latency: with accept in cycle 0, CALC SHALL occupy cycles 1..32 and resp_valid SHALL first be high in cycle 33; early-out SHALL give resp_valid in cycle 1.
REQ-022 On entry to DONE, resp_data SHALL be registered after conditional two's-complement negation.
- MUL: product[31:0].
- MULH/MULHSU/MULHU: product[63:32].
- DIV/DIVU: quotient.
- REM/REMU: remainder.
- With EARLY_OUT=0, the div-by-zero and overflow cases SHALL produce the same values via iteration.
REQ-023 In DONE, resp_valid SHALL be 1 and resp_data SHALL be held stable while resp_ready==0.
- The edge with resp_ready==1 SHALL go DONE->IDLE.
- No new request is accepted in that cycle.
REQ-024 flush SHALL have highest priority: in any state, on the edge where flush==1 the FSM SHALL go to IDLE and the counter SHALL clear.
- Any pending result is discarded; resp_valid is 0 in the next cycle.
- A request presented with flush is not accepted.
REQ-025 resp_valid SHALL be 0 in IDLE and CALC; busy SHALL be 1 in CALC and DONE.

Reset
REQ-026 rst_n==0 SHALL immediately, asynchronously set state=IDLE, counter=0, accumulators=0, resp_valid=0, resp_data=0 and busy=0.
- req_ready SHALL be 0 while rst_n==0 and 1 from the first cycle after release (flush low).
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation; no response SHALL follow deassertion.

Verification
REQ-028 MUL a=7, b=6, resp_ready=1 -> resp_valid in cycle 33, resp_data=0x0000002A, busy high cycles 1..33.
REQ-029 a=b=0xFFFFFFFF -> MULH=0x00000000, MULHU=0xFFFFFFFE, MULHSU=0xFFFFFFFF, MUL=0x00000001.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 0x00000001.
REQ-031 EARLY_OUT=1:
- DIVU a=5, b=0 -> 0xFFFFFFFF in cycle 1; REMU -> 0x00000005.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1.
- Repeat with EARLY_OUT=0 -> same values in cycle 33.
REQ-032 flush in cycle 10 of a DIV -> resp_valid never asserts, req_ready=1 in cycle 11; next MUL 3*5 -> 0x0000000F.
REQ-033 Backpressure and reset:
- resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_data stable, req_ready=0; IDLE after the accepting edge.
- rst_n pulsed low in cycle 20 of CALC -> outputs at reset values, no response.
